alu_reg: RTL and testbench
==========================

Name: alu_reg

Overview:
- 32-bit integer ALU for the RISC-V execute stage.
- Computes one of eight operations, selected by a 3-bit opcode, on two operands: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA.
- Result and ZERO/NEGATIVE status flags are registered, giving a fixed one-cycle latency, with a valid strobe alongside.
- Flags feed branch resolution downstream.

Parameters:
- WIDTH, 32, operand and result width in bits. Shift amount field width is log2(WIDTH), i.e. 5 at the default.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and opcode are valid this cycle.
- opcode  input  3  operation select (encodings below).
- in_0  input  WIDTH  first operand (shift source for shifts).
- in_1  input  WIDTH  second operand (shift amount in low 5 bits for shifts).
- out  output  WIDTH  registered result.
- ZERO  output  1  registered flag: out == 0.
- NEGATIVE  output  1  registered flag: out[WIDTH-1].
- out_valid  output  1  out/ZERO/NEGATIVE hold a new result this cycle.

Behaviour:
- Opcode encodings:
  - 3'd0 ADD: in_0 + in_1
  - 3'd1 SUB: in_0 - in_1
  - 3'd2 AND: in_0 & in_1
  - 3'd3 OR: in_0 | in_1
  - 3'd4 XOR: in_0 ^ in_1
  - 3'd5 SLL: in_0 << in_1[4:0]
  - 3'd6 SRL: logical right shift of in_0 by in_1[4:0]
  - 3'd7 SRA: arithmetic right shift of in_0 by in_1[4:0]
- Encodings are provided as `define macros ALU_OPERATION_ADD … ALU_OPERATION_SRA in a header shared with the decoder.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - No carry or overflow output.
  - SUB is two's complement, e.g. 5-20 = 32'hFFFFFFF1.
- Shifts:
  - Only in_1[4:0] is used; in_1[31:5] is ignored.
  - Shift by 0 returns in_0 unchanged.
  - SRA replicates in_0[31] into the vacated bits.
  - SLL and SRL fill with zeros.
- Flags are derived from the result being registered, not from the inputs:
  - ZERO = (result == 0).
  - NEGATIVE = result[31]. This applies to every opcode, including logical ops and shifts.
- Timing:
  - On a rising clk edge with in_valid=1, out, ZERO and NEGATIVE load the result for the presented opcode/operands, and out_valid goes to 1.
  - Latency is exactly 1 cycle; throughput is one operation per cycle with back-to-back in_valid.
  - On a rising edge with in_valid=0, out_valid goes to 0 and out/ZERO/NEGATIVE hold their previous values.
- Reset:
  - rst_n low immediately (asynchronously) forces out=0, ZERO=1, NEGATIVE=0, out_valid=0.
  - Reset asserted mid-stream discards any in-flight result.
  - The first valid result after reset release appears one edge after the first sampled in_valid=1.
- No internal state beyond the output registers; no stalls, no backpressure.
- All opcodes are defined; there is no illegal-opcode case.

Test Plan:
- Reset: assert rst_n=0 between clock edges -> out=0, ZERO=1, NEGATIVE=0, out_valid=0 without waiting for a clock edge.
- Arithmetic: present each case with in_valid=1, checking one cycle later.
  - ADD 15+10 -> out=25, Z=0, N=0.
  - SUB 20-5 -> 15, Z=0, N=0.
  - SUB 5-20 -> 32'hFFFFFFF1, N=1.
  - SUB 7-7 -> 0, Z=1.
  - ADD 32'hFFFFFFFF+1 -> 0, Z=1 (wrap).
- Logic with in_0=8'hAA, in_1=8'hCC -> AND=32'h88, OR=32'hEE, XOR=32'h66; all Z=0, N=0.
- Shifts:
  - SLL 15 by 4 -> 240.
  - SRL 120 by 3 -> 15.
  - SRA -120 by 3 -> 32'hFFFFFFF1 (N=1).
  - SRL 32'h80000000 by 31 -> 1.
  - SLL 1 with in_1=32'h21 -> 2 (only low 5 bits used).
- Handshake: issue back-to-back valid ops, then deassert in_valid.
  - out_valid tracks in_valid delayed by one cycle.
  - Outputs hold the last result while in_valid=0.
- Reset mid-stream: assert rst_n during a valid burst -> outputs clear immediately; after release with in_valid=0, out_valid stays 0.

Source files
------------

// File: rtl/alu_reg.sv
// alu_reg: 32-bit integer ALU for the RISC-V execute stage.
// One of eight operations is selected by a 3-bit opcode. The result and the
// ZERO/NEGATIVE flags are registered, giving a fixed one-cycle latency with a
// valid strobe alongside. There is no state other than the output registers.

`ifndef ALU_OPERATION_DEFS
`define ALU_OPERATION_DEFS
// Opcode encodings, shared with the instruction decoder.
`define ALU_OPERATION_ADD 3'd0
`define ALU_OPERATION_SUB 3'd1
`define ALU_OPERATION_AND 3'd2
`define ALU_OPERATION_OR  3'd3
`define ALU_OPERATION_XOR 3'd4
`define ALU_OPERATION_SLL 3'd5
`define ALU_OPERATION_SRL 3'd6
`define ALU_OPERATION_SRA 3'd7
`endif

module alu_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  output logic [WIDTH-1:0] out,
  output logic             ZERO,
  output logic             NEGATIVE,
  output logic             out_valid
);

  // Shift amount field width: 5 bits for a 32-bit datapath.
  localparam int SHW = $clog2(WIDTH);

  // ---------------------------------------------------------------------
  // Adder / subtractor: one adder shared by ADD and SUB. SUB is formed as
  // in_0 + ~in_1 + 1, so both wrap modulo 2^WIDTH with no carry kept.
  // ---------------------------------------------------------------------
  logic             is_sub;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;

  assign is_sub = (opcode == `ALU_OPERATION_SUB);
  assign addend = is_sub ? ~in_1 : in_1;
  assign sum    = in_0 + addend + {{(WIDTH-1){1'b0}}, is_sub};

  // ---------------------------------------------------------------------
  // Shifter: a single right-shifting barrel shifter serves all three
  // shifts. For SLL the source is bit-reversed on the way in and the
  // result reversed on the way out, turning a left shift into a right one.
  // The fill bit is the sign bit only for SRA; SLL and SRL fill with 0.
  // Only the low SHW bits of in_1 are used as the amount.
  // ---------------------------------------------------------------------
  logic [SHW-1:0]   shamt;
  logic             shift_left;
  logic             shift_fill;
  logic [WIDTH-1:0] in_0_rev;
  logic [WIDTH-1:0] shift_src;
  logic [WIDTH-1:0] shift_stage [SHW+1];
  logic [WIDTH-1:0] shift_right;
  logic [WIDTH-1:0] shift_right_rev;
  logic [WIDTH-1:0] shift_out;

  assign shamt      = in_1[SHW-1:0];
  assign shift_left = (opcode == `ALU_OPERATION_SLL);
  assign shift_fill = (opcode == `ALU_OPERATION_SRA) & in_0[WIDTH-1];

  genvar gi;

  // Bit reversal of the operand for the left-shift path.
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_rev_in
      assign in_0_rev[gi] = in_0[WIDTH-1-gi];
    end
  endgenerate

  assign shift_src      = shift_left ? in_0_rev : in_0;
  assign shift_stage[0] = shift_src;

  // Stage gi shifts right by 2**gi when bit gi of the amount is set.
  generate
    for (gi = 0; gi < SHW; gi = gi + 1) begin : g_shift_stage
      localparam int STEP = 1 << gi;
      assign shift_stage[gi+1] = shamt[gi]
        ? {{STEP{shift_fill}}, shift_stage[gi][WIDTH-1:STEP]}
        : shift_stage[gi];
    end
  endgenerate

  assign shift_right = shift_stage[SHW];

  // Undo the reversal for the left-shift path.
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_rev_out
      assign shift_right_rev[gi] = shift_right[WIDTH-1-gi];
    end
  endgenerate

  assign shift_out = shift_left ? shift_right_rev : shift_right;

  // ---------------------------------------------------------------------
  // Result select and flag derivation. Flags come from the result that is
  // about to be registered, for every opcode including logic and shifts.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] result_next;
  logic             zero_next;
  logic             negative_next;

  // Pick the result for the presented opcode; every encoding is defined.
  always_comb begin
    result_next = sum;
    unique case (opcode)
      `ALU_OPERATION_ADD: result_next = sum;
      `ALU_OPERATION_SUB: result_next = sum;
      `ALU_OPERATION_AND: result_next = in_0 & in_1;
      `ALU_OPERATION_OR:  result_next = in_0 | in_1;
      `ALU_OPERATION_XOR: result_next = in_0 ^ in_1;
      `ALU_OPERATION_SLL: result_next = shift_out;
      `ALU_OPERATION_SRL: result_next = shift_out;
      `ALU_OPERATION_SRA: result_next = shift_out;
      default:            result_next = sum;
    endcase
  end

  assign zero_next     = ~|result_next;
  assign negative_next = result_next[WIDTH-1];

  // ---------------------------------------------------------------------
  // Output registers. Reset clears to the flags of a zero result.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] out_reg;
  logic             zero_reg;
  logic             negative_reg;
  logic             out_valid_reg;

  // Capture result and flags on valid input; hold them otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg      <= '0;
      zero_reg     <= 1'b1;
      negative_reg <= 1'b0;
    end else if (in_valid) begin
      out_reg      <= result_next;
      zero_reg     <= zero_next;
      negative_reg <= negative_next;
    end
  end

  // Valid strobe is in_valid delayed by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
    end
  end

  assign out       = out_reg;
  assign ZERO      = zero_reg;
  assign NEGATIVE  = negative_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_alu_reg.sv
// tb_alu_reg: directed self-checking bench for alu_reg with hand-computed
// expected values; one line printed per transaction.

module tb_alu_reg;

  localparam int WIDTH = 32;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SRA = 3'd7;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] in_0;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] out;
  logic             ZERO;
  logic             NEGATIVE;
  logic             out_valid;

  int errors = 0;
  int checks = 0;

  alu_reg #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .opcode    (opcode),
    .in_0      (in_0),
    .in_1      (in_1),
    .out       (out),
    .ZERO      (ZERO),
    .NEGATIVE  (NEGATIVE),
    .out_valid (out_valid)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one valid operation, step one edge, check all outputs.
  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic exp_z, input logic exp_n);
    in_valid = 1'b1;
    opcode   = op;
    in_0     = a;
    in_1     = b;
    @(posedge clk);
    #1;
    $display("op %-10s op=%0d a=0x%08h b=0x%08h -> out=0x%08h Z=%0b N=%0b V=%0b",
             tag, op, a, b, out, ZERO, NEGATIVE, out_valid);
    check({tag, ".out"},   out,                   exp);
    check({tag, ".zero"},  {31'd0, ZERO},         {31'd0, exp_z});
    check({tag, ".neg"},   {31'd0, NEGATIVE},     {31'd0, exp_n});
    check({tag, ".valid"}, {31'd0, out_valid},    32'd1);
  endtask

  // Idle cycle with scrambled inputs: outputs must hold, valid must drop.
  task automatic do_idle(input string tag, input logic [31:0] held,
                         input logic held_z, input logic held_n);
    in_valid = 1'b0;
    opcode   = OP_XOR;
    in_0     = 32'h1234_5678;
    in_1     = 32'h8765_4321;
    @(posedge clk);
    #1;
    $display("idle %-8s -> out=0x%08h Z=%0b N=%0b V=%0b", tag, out, ZERO, NEGATIVE, out_valid);
    check({tag, ".out"},   out,                held);
    check({tag, ".zero"},  {31'd0, ZERO},      {31'd0, held_z});
    check({tag, ".neg"},   {31'd0, NEGATIVE},  {31'd0, held_n});
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    opcode   = OP_ADD;
    in_0     = '0;
    in_1     = '0;

    // Asynchronous reset between edges (t=7, edge at 5 and 15).
    #7;
    rst_n = 1'b0;
    #1;
    $display("reset asserted -> out=0x%08h Z=%0b N=%0b V=%0b", out, ZERO, NEGATIVE, out_valid);
    check("rst.out",   out,                32'd0);
    check("rst.zero",  {31'd0, ZERO},      32'd1);
    check("rst.neg",   {31'd0, NEGATIVE},  32'd0);
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst.valid", {31'd0, out_valid}, 32'd0);

    // Arithmetic, back to back.
    do_op("add",      OP_ADD, 32'd15,         32'd10, 32'd25,         1'b0, 1'b0);
    do_op("sub",      OP_SUB, 32'd20,         32'd5,  32'd15,         1'b0, 1'b0);
    do_op("sub_neg",  OP_SUB, 32'd5,          32'd20, 32'hFFFF_FFF1,  1'b0, 1'b1);
    do_op("sub_zero", OP_SUB, 32'd7,          32'd7,  32'd0,          1'b1, 1'b0);
    do_op("add_wrap", OP_ADD, 32'hFFFF_FFFF,  32'd1,  32'd0,          1'b1, 1'b0);

    // Logic.
    do_op("and", OP_AND, 32'h0000_00AA, 32'h0000_00CC, 32'h0000_0088, 1'b0, 1'b0);
    do_op("or",  OP_OR,  32'h0000_00AA, 32'h0000_00CC, 32'h0000_00EE, 1'b0, 1'b0);
    do_op("xor", OP_XOR, 32'h0000_00AA, 32'h0000_00CC, 32'h0000_0066, 1'b0, 1'b0);
    do_op("xor_neg", OP_XOR, 32'hF000_000F, 32'h0000_000F, 32'hF000_0000, 1'b0, 1'b1);

    // Shifts.
    do_op("sll",      OP_SLL, 32'd15,        32'd4,         32'd240,       1'b0, 1'b0);
    do_op("srl",      OP_SRL, 32'd120,       32'd3,         32'd15,        1'b0, 1'b0);
    do_op("sra_neg",  OP_SRA, 32'hFFFF_FF88, 32'd3,         32'hFFFF_FFF1, 1'b0, 1'b1);
    do_op("srl_31",   OP_SRL, 32'h8000_0000, 32'd31,        32'd1,         1'b0, 1'b0);
    do_op("sll_mask", OP_SLL, 32'd1,         32'h0000_0021, 32'd2,         1'b0, 1'b0);
    do_op("sll_31",   OP_SLL, 32'd1,         32'd31,        32'h8000_0000, 1'b0, 1'b1);
    do_op("sra_0",    OP_SRA, 32'h8000_0001, 32'hFFFF_FFE0, 32'h8000_0001, 1'b0, 1'b1);
    do_op("sra_pos",  OP_SRA, 32'h7000_0000, 32'd4,         32'h0700_0000, 1'b0, 1'b0);
    do_op("srl_neg",  OP_SRL, 32'hF000_0000, 32'd4,         32'h0F00_0000, 1'b0, 1'b0);
    do_op("sll_out",  OP_SLL, 32'h0000_0003, 32'd31,        32'h8000_0000, 1'b0, 1'b1);

    // Drop in_valid: last result must be held, valid low.
    do_idle("hold1", 32'h8000_0000, 1'b0, 1'b1);
    do_idle("hold2", 32'h8000_0000, 1'b0, 1'b1);

    // Resume, then reset in the middle of a valid burst.
    do_op("resume", OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    in_valid = 1'b1;
    opcode   = OP_ADD;
    in_0     = 32'd100;
    in_1     = 32'd200;
    #2;
    rst_n = 1'b0;
    #1;
    $display("reset mid-stream -> out=0x%08h Z=%0b N=%0b V=%0b", out, ZERO, NEGATIVE, out_valid);
    check("mid_rst.out",   out,                32'd0);
    check("mid_rst.zero",  {31'd0, ZERO},      32'd1);
    check("mid_rst.neg",   {31'd0, NEGATIVE},  32'd0);
    check("mid_rst.valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("in_rst.out", out, 32'd0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("after release idle -> out=0x%08h Z=%0b N=%0b V=%0b", out, ZERO, NEGATIVE, out_valid);
    check("rel.valid1", {31'd0, out_valid}, 32'd0);
    check("rel.out1",   out,                32'd0);
    @(posedge clk);
    #1;
    check("rel.valid2", {31'd0, out_valid}, 32'd0);
    check("rel.zero2",  {31'd0, ZERO},      32'd1);

    // First valid op after release appears one edge later.
    do_op("first", OP_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
    do_idle("tail", 32'd7, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
